conv_pool_sequencer: RTL and testbench

- Top-level step sequencer for one 3x3-conv + 2x2-maxpool layer.
- Drives the layer's read-address generator with loop indices and enables.
- Emits MAC/pool control strobes aligned to returning RAM data, plus output-buffer write enable and address.
- Iterates all channels, pooled rows, pooled columns, 4 pool positions and 9 taps; then flushes the pipeline and signals completion.

---
 rtl/conv_pool_sequencer.sv | 115 +++++++++++
 tb/tb_conv_pool_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_sequencer.sv
// conv_pool_sequencer: loop sequencer for one 3x3-conv + 2x2-maxpool layer with data-aligned MAC/pool strobes.
// Optional stall-cycle counter enabled by defining CONV_SEQ_STALL_CNT_EN.
module conv_pool_sequencer #(
  parameter int WIDTH    = 14,
  parameter int HEIGHT   = 18,
  parameter int NUM_CH   = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTALL,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oRD_EN,
  output logic [3:0]  oTAP,
  output logic [1:0]  oPOS,
  output logic [3:0]  oCOL,
  output logic [3:0]  oROW,
  output logic [1:0]  oCH,
  output logic        oMAC_CLR,
  output logic        oMAC_LAST,
  output logic        oPOOL_FIRST,
  output logic        oWR_EN,
  output logic [8:0]  oWR_ADDR,
  output logic [15:0] oSTALL_CNT
);
  localparam int OUT_W = (WIDTH - 2) / 2;
  localparam int OUT_H = (HEIGHT - 2) / 2;
  localparam logic [3:0] COL_MAX = 4'(OUT_W - 1);
  localparam logic [3:0] ROW_MAX = 4'(OUT_H - 1);
  localparam logic [1:0] CH_MAX  = 2'(NUM_CH - 1);
  localparam logic [2:0] FL_MAX  = 3'(PIPE_LAT);
  localparam logic [8:0] ROW_SZ  = 9'(OUT_W);
  localparam logic [8:0] CH_SZ   = 9'(OUT_W * OUT_H);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_tap, r_col, r_row;
  logic [1:0] r_pos, r_ch;
  logic [2:0] r_fl;
  logic       r_wr_en;
  logic [8:0] r_wr_addr;
  logic       w_rd, w_tap_w, w_pos_w, w_col_w, w_row_w, w_last, w_wr;
  logic [8:0] w_addr;
  // Stage layout: {valid, tap==0, tap==8, pos==0, pos==3, addr[8:0]}
  logic [13:0] r_dl [PIPE_LAT];
  logic [13:0] w_tail;
  assign w_tail = r_dl[PIPE_LAT-1];
  always_comb begin
    w_rd    = (r_state == S_RUN) && !iSTALL;
    w_tap_w = r_tap == 4'd8;
    w_pos_w = w_tap_w && (r_pos == 2'd3);
    w_col_w = w_pos_w && (r_col == COL_MAX);
    w_row_w = w_col_w && (r_row == ROW_MAX);
    w_last  = w_row_w && (r_ch == CH_MAX);
    w_wr    = w_tail[13] && w_tail[11] && w_tail[9];
    w_addr  = 9'(r_ch) * CH_SZ + 9'(r_row) * ROW_SZ + 9'(r_col);
    w_next  = r_state == S_IDLE  ? (iSTART ? S_RUN : S_IDLE) :
              r_state == S_RUN   ? ((w_rd && w_last) ? S_FLUSH : S_RUN) :
              r_state == S_FLUSH ? ((r_fl == FL_MAX) ? S_DONE : S_FLUSH) :
              S_IDLE;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_tap     <= '0;
      r_pos     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_ch      <= '0;
      r_fl      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      for (int k = 0; k < PIPE_LAT; k++) r_dl[k] <= '0;
    end else begin
      r_state <= w_next;
      r_fl    <= (r_state == S_FLUSH) ? r_fl + 3'd1 : 3'd0;
      if (w_rd) begin
        r_tap <= w_tap_w ? 4'd0 : r_tap + 4'd1;
        r_pos <= r_pos + 2'(w_tap_w);
        r_col <= w_col_w ? 4'd0 : r_col + 4'(w_pos_w);
        r_row <= w_row_w ? 4'd0 : r_row + 4'(w_col_w);
        r_ch  <= w_last  ? 2'd0 : r_ch + 2'(w_row_w);
      end
      // Shifts every cycle; a stalled cycle enters as a bubble with valid=0
      r_dl[0] <= {w_rd, r_tap == 4'd0, w_tap_w, r_pos == 2'd0, r_pos == 2'd3, w_addr};
      for (int k = 1; k < PIPE_LAT; k++) r_dl[k] <= r_dl[k-1];
      r_wr_en <= w_wr;
      if (w_wr) r_wr_addr <= w_tail[8:0];
    end
  end
  assign oBUSY       = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign oDONE       = r_state == S_DONE;
  assign oRD_EN      = w_rd;
  assign oTAP        = r_tap;
  assign oPOS        = r_pos;
  assign oCOL        = r_col;
  assign oROW        = r_row;
  assign oCH         = r_ch;
  assign oMAC_CLR    = w_tail[13] && w_tail[12];
  assign oMAC_LAST   = w_tail[13] && w_tail[11];
  assign oPOOL_FIRST = w_tail[13] && w_tail[11] && w_tail[10];
  assign oWR_EN      = r_wr_en;
  assign oWR_ADDR    = r_wr_addr;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge iCLK) begin
    if (iRST || (r_state == S_IDLE && iSTART)) r_stall_cnt <= '0;
    else if (r_state == S_RUN && iSTALL && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign oSTALL_CNT = r_stall_cnt;
`else
  assign oSTALL_CNT = '0;
`endif
endmodule

// File: tb/tb_conv_pool_sequencer.sv
// tb_conv_pool_sequencer: randomized-stall bench against a read-schedule model of the layer sequencer.
module tb_conv_pool_sequencer;
  localparam int OW = 6, OH = 8, MAXC = 8192;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic st [2];
  logic sl [2];
  logic a_busy [2], a_done [2], a_rd [2], a_clr [2], a_last [2], a_pf [2], a_wr [2];
  logic [3:0] a_tap [2], a_col [2], a_row [2];
  logic [1:0] a_pos [2], a_ch [2];
  logic [8:0] a_addr [2];
  logic [15:0] a_sc [2];
  int checks = 0, failures = 0;
  bit stl [MAXC];
  bit e_busy [MAXC], e_done [MAXC], e_rd [MAXC], e_iv [MAXC];
  bit e_clr [MAXC], e_last [MAXC], e_pf [MAXC], e_wr [MAXC];
  logic [3:0] e_tap [MAXC], e_col [MAXC], e_row [MAXC];
  logic [1:0] e_pos [MAXC], e_ch [MAXC];
  logic [8:0] e_addr [MAXC];
  int e_end, e_nst;
  int first_wr, first_addr, first_clr, first_pf, nwr, nrd, ndone, done_c;

  conv_pool_sequencer u0 (
    .iCLK(clk), .iRST(rst), .iSTART(st[0]), .iSTALL(sl[0]),
    .oBUSY(a_busy[0]), .oDONE(a_done[0]), .oRD_EN(a_rd[0]), .oTAP(a_tap[0]), .oPOS(a_pos[0]),
    .oCOL(a_col[0]), .oROW(a_row[0]), .oCH(a_ch[0]), .oMAC_CLR(a_clr[0]), .oMAC_LAST(a_last[0]),
    .oPOOL_FIRST(a_pf[0]), .oWR_EN(a_wr[0]), .oWR_ADDR(a_addr[0]), .oSTALL_CNT(a_sc[0]));

  conv_pool_sequencer #(.NUM_CH(1), .PIPE_LAT(1)) u1 (
    .iCLK(clk), .iRST(rst), .iSTART(st[1]), .iSTALL(sl[1]),
    .oBUSY(a_busy[1]), .oDONE(a_done[1]), .oRD_EN(a_rd[1]), .oTAP(a_tap[1]), .oPOS(a_pos[1]),
    .oCOL(a_col[1]), .oROW(a_row[1]), .oCH(a_ch[1]), .oMAC_CLR(a_clr[1]), .oMAC_LAST(a_last[1]),
    .oPOOL_FIRST(a_pf[1]), .oWR_EN(a_wr[1]), .oWR_ADDR(a_addr[1]), .oSTALL_CNT(a_sc[1]));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int d);
    chk($sformatf("reset_zero_dut%0d", d),
        {a_busy[d], a_done[d], a_rd[d], a_tap[d], a_pos[d], a_col[d], a_row[d], a_ch[d],
         a_clr[d], a_last[d], a_pf[d], a_wr[d], a_addr[d], a_sc[d]}, 0);
  endtask

  // Read k lands on the k-th non-stalled RUN cycle; everything else follows from k and that cycle.
  task automatic build(input int lat, input int nch);
    int n = 36 * OW * OH * nch;
    int k = 0;
    int c = 0;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_iv[i] = 0;
      e_clr[i] = 0; e_last[i] = 0; e_pf[i] = 0; e_wr[i] = 0;
      e_tap[i] = 0; e_pos[i] = 0; e_col[i] = 0; e_row[i] = 0; e_ch[i] = 0; e_addr[i] = 0;
    end
    e_nst = 0;
    while (k < n) begin
      e_busy[c] = 1;
      e_iv[c]   = 1;
      e_tap[c]  = 4'(k % 9);
      e_pos[c]  = 2'((k / 9) % 4);
      e_col[c]  = 4'((k / 36) % OW);
      e_row[c]  = 4'((k / (36 * OW)) % OH);
      e_ch[c]   = 2'(k / (36 * OW * OH));
      if (stl[c]) e_nst++;
      else begin
        e_rd[c] = 1;
        if (k % 9 == 0) e_clr[c+lat] = 1;
        if (k % 9 == 8) e_last[c+lat] = 1;
        if (k % 36 == 8) e_pf[c+lat] = 1;
        if (k % 36 == 35) begin
          e_wr[c+lat+1]   = 1;
          e_addr[c+lat+1] = 9'(k / 36);
        end
        k++;
      end
      c++;
    end
    for (int i = c; i <= c + lat; i++) e_busy[i] = 1;
    e_end = c + lat + 1;
    e_done[e_end] = 1;
    e_iv[e_end+1] = 1;
  endtask

  task automatic cmp(input int d, input int c);
    logic [31:0] av, ev;
    av = {a_busy[d], a_done[d], a_rd[d],
          e_iv[c] ? {a_tap[d], a_pos[d], a_col[d], a_row[d], a_ch[d]} : 16'd0,
          a_clr[d], a_last[d], a_pf[d], a_wr[d], e_wr[c] ? a_addr[d] : 9'd0};
    ev = {e_busy[c], e_done[c], e_rd[c],
          e_iv[c] ? {e_tap[c], e_pos[c], e_col[c], e_row[c], e_ch[c]} : 16'd0,
          e_clr[c], e_last[c], e_pf[c], e_wr[c], e_wr[c] ? e_addr[c] : 9'd0};
    checks++;
    if (av !== ev) begin
      failures++;
      $display("FAIL cycle dut%0d c=%0d got=%h expected=%h", d, c, av, ev);
    end
    if (a_rd[d]) nrd++;
    if (a_wr[d]) begin
      if (first_wr < 0) begin first_wr = c; first_addr = a_addr[d]; end
      nwr++;
    end
    if (a_clr[d] && first_clr < 0) first_clr = c;
    if (a_pf[d] && first_pf < 0) first_pf = c;
    if (a_done[d]) begin ndone++; done_c = c; end
  endtask

  task automatic run(input int d, input int lat, input int nch, input int abort, input int sp, input bit late);
    build(lat, nch);
    first_wr = -1; first_addr = -1; first_clr = -1; first_pf = -1;
    nwr = 0; nrd = 0; ndone = 0; done_c = -1;
    @(posedge clk); #1 st[d] = 1'b1;
    @(posedge clk); #1 st[d] = 1'b0;
    for (int c = 0; c <= e_end + 1; c++) begin
      sl[d] = stl[c];
      st[d] = (c == sp) || (late && c == e_end - 1);
      if (c == abort) rst = 1'b1;
      @(negedge clk);
      cmp(d, c);
      @(posedge clk); #1;
      if (c == abort) begin
        rst = 1'b0; sl[d] = 1'b0; st[d] = 1'b0;
        @(negedge clk);
        chk_zero(d);
        return;
      end
    end
    sl[d] = 1'b0;
    st[d] = 1'b0;
`ifdef CONV_SEQ_STALL_CNT_EN
    chk("stall_cnt", a_sc[d], e_nst);
`else
    chk("stall_cnt", a_sc[d], 0);
`endif
  endtask

  task automatic rand_stalls();
    for (int i = 0; i < MAXC; i++) stl[i] = (i < 6000) && ($urandom_range(0, 99) < 20);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin st[i] = 1'b0; sl[i] = 1'b0; end
    for (int i = 0; i < MAXC; i++) stl[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    @(posedge clk); #1 rst = 1'b0;

    run(0, 2, 2, -1, -1, 0);
    chk("t1_first_wr", first_wr, 38);
    chk("t1_first_addr", first_addr, 0);
    chk("t1_first_clr", first_clr, 2);
    chk("t1_first_pf", first_pf, 10);
    chk("t1_reads", nrd, 3456);
    chk("t1_writes", nwr, 96);
    chk("t1_done_cycle", done_c, 3459);
    chk("t1_done_count", ndone, 1);

    for (int i = 7; i < 12; i++) stl[i] = 1;
    run(0, 2, 2, -1, 500, 1);
    chk("t2_first_wr", first_wr, 43);
    chk("t2_writes", nwr, 96);
    chk("t2_done_cycle", done_c, 3464);
    chk("t2_done_count", ndone, 1);
`ifdef CONV_SEQ_STALL_CNT_EN
    chk("t2_stall_cnt", a_sc[0], 5);
`else
    chk("t2_stall_cnt", a_sc[0], 0);
`endif

    rand_stalls();
    run(0, 2, 2, -1, 1234, 1);
    chk("t3_writes", nwr, 96);
    chk("t3_reads", nrd, 3456);

    for (int i = 0; i < MAXC; i++) stl[i] = 0;
    run(0, 2, 2, 1000, -1, 0);
    run(0, 2, 2, -1, -1, 0);
    chk("t4_first_addr", first_addr, 0);
    chk("t4_writes", nwr, 96);

    run(1, 1, 1, -1, -1, 0);
    chk("t5_first_wr", first_wr, 37);
    chk("t5_reads", nrd, 1728);
    chk("t5_writes", nwr, 48);
    chk("t5_done_cycle", done_c, 1730);

    rand_stalls();
    run(1, 1, 1, -1, 300, 1);
    chk("t6_writes", nwr, 48);
    chk("t6_done_count", ndone, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
